// File: rtl/bias_bank.sv
// bias_bank: signed bias storage for a small neural-network datapath.
// After reset the bank sweeps DEFAULT_BIAS into every entry (INIT), then
// serves registered single-cycle reads and accepts a streamed load of new
// words (IDLE). Out-of-range read indices return zero with an error pulse.
//
// Load handshake: ld_ready is high exactly while the bank is in IDLE; a word
// transfers on every rising edge where ld_valid and ld_ready are both high.
// ld_valid may be held high for back-to-back transfers, and ld_data must be
// stable while ld_valid is high. There is no backpressure once IDLE.
module bias_bank #(
   parameter int DATA_W       = 8,
   parameter int DEPTH        = 49,
   parameter int ADDR_W       = 16,
   parameter int IDX_W        = 6,
   parameter int DEFAULT_BIAS = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] input_addr,
   output logic [DATA_W-1:0] bias_val,
   output logic              bias_valid,
   output logic              bias_err,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              ld_done,
   output logic              busy
);

   typedef enum logic {
      INIT = 1'b0,
      IDLE = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W:0]    DEPTH_X  = (IDX_W + 1)'(DEPTH);
   localparam logic [DATA_W-1:0] DEF_WORD = DATA_W'(DEFAULT_BIAS);

   // Storage is deliberately not reset; only the INIT sweep initialises it.
   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  sweep_ptr;
   logic [IDX_W-1:0]  ld_ptr;
   logic [IDX_W-1:0]  rd_idx;
   logic              rd_in_range;
   logic              rd_fire;
   logic              ld_fire;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic              unused_addr_bits;

   assign rd_idx           = input_addr[ADDR_W-1 -: IDX_W];
   assign rd_in_range      = ({1'b0, rd_idx} < DEPTH_X);
   assign unused_addr_bits = ^input_addr[ADDR_W-IDX_W-1:0];

   assign ld_fire = ld_valid & ld_ready;
   assign rd_fire = rd_en & (state == IDLE);

   // State register; reset always restarts the init sweep.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= INIT;
      else        state <= state_nxt;
   end

   // Next state and state-decoded outputs (busy, ld_ready).
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      ld_ready  = 1'b0;
      case (state)
         INIT: begin
            busy = 1'b1;
            if (sweep_ptr == LAST_IDX) state_nxt = IDLE;
         end
         IDLE: begin
            ld_ready = 1'b1;
         end
         default: state_nxt = INIT;
      endcase
   end

   // Sweep pointer walks 0..DEPTH-1 once per INIT visit, one entry per cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sweep_ptr <= '0;
      end else if (state == INIT) begin
         sweep_ptr <= (sweep_ptr == LAST_IDX) ? '0 : sweep_ptr + 1'b1;
      end
   end

   // Load pointer advances per transfer and wraps after the last entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ld_ptr <= '0;
      end else if (ld_fire) begin
         ld_ptr <= (ld_ptr == LAST_IDX) ? '0 : ld_ptr + 1'b1;
      end
   end

   // ld_done pulses in the cycle after the last entry was written.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ld_done <= 1'b0;
      else        ld_done <= ld_fire & (ld_ptr == LAST_IDX);
   end

   // Single write port shared by the init sweep and the load stream.
   always_comb begin
      wr_en   = busy | ld_fire;
      wr_idx  = busy ? sweep_ptr : ld_ptr;
      wr_data = busy ? DEF_WORD  : ld_data;
   end

   // Memory write; a same-edge read sees the pre-write contents.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   // Registered read; bias_val holds between reads.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bias_val   <= '0;
         bias_valid <= 1'b0;
         bias_err   <= 1'b0;
      end else begin
         bias_valid <= rd_fire;
         bias_err   <= rd_fire & ~rd_in_range;
         if (rd_fire) bias_val <= rd_in_range ? mem[rd_idx] : '0;
      end
   end

endmodule

// File: tb/tb_bias_bank.sv
// Testbench for bias_bank: behavioural model of the bank contents and
// per-cycle expectations, a read scoreboard, vector table and corner cases.
module tb_bias_bank;

   localparam int DATA_W       = 8;
   localparam int DEPTH        = 49;
   localparam int ADDR_W       = 16;
   localparam int IDX_W        = 6;
   localparam int DEFAULT_BIAS = 2;

   logic              clk;
   logic              reset;
   logic              rd_en;
   logic [ADDR_W-1:0] input_addr;
   logic [DATA_W-1:0] bias_val;
   logic              bias_valid;
   logic              bias_err;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              ld_done;
   logic              busy;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: bank contents, remaining sweep cycles, load pointer, last read.
   logic [7:0] m_mem [64];
   int         m_init_left;
   int         m_ldptr;
   logic [7:0] m_val;
   int         done_count;

   logic [8:0] exp_q [$];

   typedef struct {
      logic       rd;
      int         idx;
      logic [7:0] exp_val;
      logic       exp_valid;
      logic       exp_err;
   } vec_t;

   vec_t tbl [8];

   bias_bank #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .IDX_W(IDX_W), .DEFAULT_BIAS(DEFAULT_BIAS)
   ) dut (
      .clk(clk), .reset(reset), .rd_en(rd_en), .input_addr(input_addr),
      .bias_val(bias_val), .bias_valid(bias_valid), .bias_err(bias_err),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .ld_done(ld_done), .busy(busy)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_init_left = DEPTH;
      m_ldptr     = 0;
      m_val       = 8'h00;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bias_val"},   bias_val,   0);
      check({tag, "_bias_valid"}, bias_valid, 0);
      check({tag, "_bias_err"},   bias_err,   0);
      check({tag, "_ld_done"},    ld_done,    0);
      check({tag, "_ld_ready"},   ld_ready,   0);
      check({tag, "_busy"},       busy,       1);
   endtask

   // One clock cycle: drive inputs, predict, clock, compare.
   task automatic cycle(input logic rd, input int idx, input logic ldv, input logic [7:0] ldd);
      logic       e_valid, e_err, e_done;
      logic [5:0] i6;
      logic [8:0] got;
      i6         = idx[5:0];
      rd_en      = rd;
      input_addr = {i6, 10'($urandom)};
      ld_valid   = ldv;
      ld_data    = ldd;
      e_valid = 1'b0;
      e_err   = 1'b0;
      e_done  = 1'b0;
      if (m_init_left > 0) begin
         m_mem[DEPTH - m_init_left] = 8'(DEFAULT_BIAS);
         m_init_left--;
      end else begin
         if (rd) begin
            e_valid = 1'b1;
            if (idx < DEPTH) m_val = m_mem[idx];
            else begin
               m_val = 8'h00;
               e_err = 1'b1;
            end
            exp_q.push_back({e_err, m_val});
         end
         if (ldv) begin
            m_mem[m_ldptr] = ldd;
            e_done  = (m_ldptr == DEPTH - 1);
            m_ldptr = (m_ldptr + 1) % DEPTH;
         end
      end
      @(posedge clk);
      #1;
      check("bias_val",   bias_val,   m_val);
      check("bias_valid", bias_valid, e_valid);
      check("bias_err",   bias_err,   e_err);
      check("ld_done",    ld_done,    e_done);
      check("busy",       busy,       m_init_left > 0);
      check("ld_ready",   ld_ready,   m_init_left == 0);
      if (ld_done) done_count++;
      if (bias_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: got valid read %0h expected none", bias_val);
         end else begin
            got = exp_q.pop_front();
            check("sb_read", {bias_err, bias_val}, got);
         end
      end
   endtask

   task automatic count_sweep(input string tag);
      int cnt;
      cnt = 0;
      while (busy && cnt < 200) begin
         cycle(1'($urandom_range(0, 1)), $urandom_range(0, 63), 1'($urandom_range(0, 1)), 8'($urandom));
         cnt++;
      end
      check({tag, "_busy_cycles"}, cnt, DEPTH);
   endtask

   initial begin
      int nz;
      tbl[0] = '{1'b1,  5, 8'hFB, 1'b1, 1'b0};
      tbl[1] = '{1'b1,  0, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 48, 8'hD0, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 49, 8'h00, 1'b1, 1'b1};
      tbl[4] = '{1'b1,  1, 8'hFF, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 63, 8'h00, 1'b1, 1'b1};
      tbl[6] = '{1'b0,  5, 8'h00, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 47, 8'hD1, 1'b1, 1'b0};

      reset      = 1'b0;
      rd_en      = 1'b0;
      input_addr = '0;
      ld_valid   = 1'b0;
      ld_data    = '0;
      done_count = 0;
      model_reset();

      // Reset values before any clock edge.
      #3;
      check_reset_outputs("por");
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Init sweep with random (ignored) reads/loads.
      count_sweep("init");

      // Default bias readback.
      cycle(1'b1, 0, 1'b0, 8'h00);
      check("rd0_default", bias_val, 2);
      cycle(1'b1, 16, 1'b0, 8'h00);
      check("rd16_default", bias_val, 2);
      cycle(1'b1, 48, 1'b0, 8'h00);
      check("rd48_default", bias_val, 2);
      cycle(1'b0, 0, 1'b0, 8'h00);
      check("idle_no_valid", bias_valid, 0);

      // Same-cycle load and read of entry 3 returns old value.
      cycle(1'b0, 0, 1'b1, 8'h10);
      cycle(1'b0, 0, 1'b1, 8'h11);
      cycle(1'b0, 0, 1'b1, 8'h12);
      cycle(1'b1, 3, 1'b1, 8'h7F);
      check("rw_same_old", bias_val, 2);
      cycle(1'b1, 3, 1'b0, 8'h00);
      check("rw_next_new", bias_val, 8'h7F);

      // Finish the partial pass so the pointer wraps.
      done_count = 0;
      for (int k = 4; k < DEPTH; k++) cycle(1'b0, 0, 1'b1, 8'(k));
      check("wrap_done_count", done_count, 1);

      // Full stream of -k with ld_valid held.
      done_count = 0;
      for (int k = 0; k < DEPTH; k++) cycle(1'b0, 0, 1'b1, 8'(-k));
      check("stream_done_pulse", ld_done, 1);
      check("stream_done_count", done_count, 1);

      // Vector table.
      for (int i = 0; i < 8; i++) begin
         cycle(tbl[i].rd, tbl[i].idx, 1'b0, 8'h00);
         check($sformatf("tbl%0d_val", i),   bias_val,   tbl[i].exp_val);
         check($sformatf("tbl%0d_valid", i), bias_valid, tbl[i].exp_valid);
         check($sformatf("tbl%0d_err", i),   bias_err,   tbl[i].exp_err);
      end

      // Back-to-back reads during a load stream.
      for (int k = 0; k < 10; k++) begin
         if (k >= 3 && k <= 5) begin
            cycle(1'b1, k - 3, 1'b1, 8'(8'h40 + k));
            check($sformatf("b2b_val%0d", k - 3), bias_val, 8'(8'h40 + k - 3));
            check($sformatf("b2b_valid%0d", k - 3), bias_valid, 1);
         end else begin
            cycle(1'b0, 0, 1'b1, 8'(8'h40 + k));
         end
      end

      // Random traffic against the model.
      for (int n = 0; n < 400; n++)
         cycle(1'($urandom_range(0, 1)), $urandom_range(0, 63), 1'($urandom_range(0, 1)), 8'($urandom));

      // Async reset in IDLE with a non-zero bias_val on the output.
      nz = 0;
      for (int i = 0; i < DEPTH; i++) if (m_mem[i] != 8'h00 && nz == 0) nz = i;
      cycle(1'b1, nz, 1'b1, 8'h55);
      rd_en    = 1'b0;
      ld_valid = 1'b0;
      reset    = 1'b0;
      #2;
      check_reset_outputs("idle_rst");
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Reset at sweep cycle 20: a fresh full sweep follows.
      for (int n = 0; n < 20; n++) cycle(1'b1, n, 1'b1, 8'h33);
      reset = 1'b0;
      #2;
      check_reset_outputs("sweep_rst");
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      count_sweep("resweep");
      cycle(1'b1, 0, 1'b0, 8'h00);
      check("resweep_rd0", bias_val, 2);
      cycle(1'b1, 3, 1'b0, 8'h00);
      check("resweep_rd3", bias_val, 2);

      check("sb_drain", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
